serial_add_unit: RTL and testbench

//  Parametrised multi-cycle successor of the single-bit half adder: adds two WIDTH-bit operands

---
 rtl/serial_add_unit.sv | 136 +++++++++++++
 tb/tb_serial_add_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_unit.sv
// +-----------------------------------------------------------------------------+
// | serial_add_unit: LSB-first digit-serial adder with valid/ready handshakes.  |
// | Option: SERIAL_ADD_UNIT_SUB_EN adds sub_i (a - b).  Rev 1.0                 |
// +-----------------------------------------------------------------------------+
`default_nettype none

module serial_add_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef SERIAL_ADD_UNIT_SUB_EN
  input  logic             sub_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_err
    $error("serial_add_unit: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   w_dig;
  logic [WIDTH-1:0] w_sum_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  assign w_dig = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

  // Result digits enter at the MSB end so the final digit lands the sum in place.
  if (DIGIT == WIDTH) begin : g_shift_full
    assign w_sum_next = w_dig[DIGIT-1:0];
  end else begin : g_shift_part
    assign w_sum_next = {w_dig[DIGIT-1:0], sum_q[WIDTH-1:DIGIT]};
  end

`ifdef SERIAL_ADD_UNIT_SUB_EN
  // Subtraction is a + ~b + 1, so only the loaded operand and carry differ.
  assign w_b_load = sub_i ? ~b_i : b_i;
  assign w_c_load = sub_i ? 1'b1 : cin_i;
`else
  assign w_b_load = b_i;
  assign w_c_load = cin_i;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = w_b_load;
          carry_d = w_c_load;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = w_sum_next;
        carry_d = w_dig[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          cout_d  = w_dig[DIGIT];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q == ST_RUN);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_unit.sv
// +-----------------------------------------------------------------------------+
// | tb_serial_add_unit: directed checks of serial_add_unit (DIGIT=1 and 4).    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_add_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v1 = 1'b0, c1 = 1'b0, or1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0;
  logic       ir1, ov1, co1, bz1;
  logic [7:0] s1;

  logic       v4 = 1'b0, c4 = 1'b0, or4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0;
  logic       ir4, ov4, co4, bz4;
  logic [7:0] s4;

`ifdef SERIAL_ADD_UNIT_SUB_EN
  logic sub1 = 1'b0, sub4 = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serial_add_unit #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v1), .in_ready_o(ir1),
    .a_i(a1), .b_i(b1), .cin_i(c1),
`ifdef SERIAL_ADD_UNIT_SUB_EN
    .sub_i(sub1),
`endif
    .out_valid_o(ov1), .out_ready_i(or1), .sum_o(s1), .cout_o(co1), .busy_o(bz1)
  );

  serial_add_unit #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v4), .in_ready_o(ir4),
    .a_i(a4), .b_i(b4), .cin_i(c4),
`ifdef SERIAL_ADD_UNIT_SUB_EN
    .sub_i(sub4),
`endif
    .out_valid_o(ov4), .out_ready_i(or4), .sum_o(s4), .cout_o(co4), .busy_o(bz4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset held across clock edges
    tick(2);
    check("rst_in_ready", ir1, 1);
    check("rst_out_valid", ov1, 0);
    check("rst_busy", bz1, 0);
    check("rst_sum", s1, 8'h00);
    check("rst_cout", co1, 0);
    check("rst_d4_in_ready", ir4, 1);
    rst_n = 1'b1;
    tick(1);

    // 35 + 4A, then backpressure in DONE
    a1 = 8'h35; b1 = 8'h4A; c1 = 1'b0; v1 = 1'b1;
    tick(1);
    v1 = 1'b0;
    check("t2_busy", bz1, 1);
    check("t2_in_ready_low", ir1, 0);
    tick(7);
    check("t2_not_yet_valid", ov1, 0);
    tick(1);
    check("t2_valid", ov1, 1);
    check("t2_sum", s1, 8'h7F);
    check("t2_cout", co1, 0);
    for (int i = 0; i < 5; i++) begin
      v1 = (i % 2 == 0);
      a1 = 8'hAA;
      tick(1);
      check("bp_valid_held", ov1, 1);
      check("bp_in_ready", ir1, 0);
      check("bp_sum_stable", s1, 8'h7F);
      check("bp_cout_stable", co1, 0);
    end
    v1 = 1'b0;
    or1 = 1'b1;
    tick(1);
    or1 = 1'b0;
    check("bp_idle_in_ready", ir1, 1);
    check("bp_idle_valid", ov1, 0);
    check("bp_sum_hold", s1, 8'h7F);

    // wrap on both widths: FF + 01 + 1
    a1 = 8'hFF; b1 = 8'h01; c1 = 1'b1; v1 = 1'b1;
    a4 = 8'hFF; b4 = 8'h01; c4 = 1'b1; v4 = 1'b1;
    tick(1);
    v1 = 1'b0; v4 = 1'b0;
    tick(1);
    check("t3_d4_not_yet", ov4, 0);
    tick(1);
    check("t3_d4_valid", ov4, 1);
    check("t3_d4_sum", s4, 8'h01);
    check("t3_d4_cout", co4, 1);
    tick(6);
    check("t3_d1_valid", ov1, 1);
    check("t3_d1_sum", s1, 8'h01);
    check("t3_d1_cout", co1, 1);
    or1 = 1'b1; or4 = 1'b1;
    tick(1);
    or1 = 1'b0; or4 = 1'b0;

    // D4: 9C + 47 + 1 = E4
    a4 = 8'h9C; b4 = 8'h47; c4 = 1'b1; v4 = 1'b1;
    tick(1);
    v4 = 1'b0;
    tick(2);
    check("d4_b_sum", s4, 8'hE4);
    check("d4_b_cout", co4, 0);
    or4 = 1'b1;
    tick(1);
    or4 = 1'b0;

    // back-to-back with in_valid held
    or1 = 1'b1; a1 = 8'h01; b1 = 8'h02; c1 = 1'b0; v1 = 1'b1;
    tick(1);
    a1 = 8'h80; b1 = 8'h80;
    tick(8);
    check("b2b_1_valid", ov1, 1);
    check("b2b_1_sum", s1, 8'h03);
    check("b2b_1_cout", co1, 0);
    tick(1);
    check("b2b_idle", ir1, 1);
    tick(1);
    check("b2b_2_accepted", bz1, 1);
    tick(7);
    check("b2b_2_not_yet", ov1, 0);
    tick(1);
    check("b2b_2_valid", ov1, 1);
    check("b2b_2_sum", s1, 8'h00);
    check("b2b_2_cout", co1, 1);
    v1 = 1'b0;
    tick(1);
    or1 = 1'b0;

    // asynchronous reset in the middle of RUN
    a1 = 8'hFF; b1 = 8'hFF; c1 = 1'b0; v1 = 1'b1;
    tick(1);
    v1 = 1'b0;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", ir1, 1);
    check("arst_out_valid", ov1, 0);
    check("arst_busy", bz1, 0);
    check("arst_sum", s1, 8'h00);
    check("arst_cout", co1, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    a1 = 8'h12; b1 = 8'h34; c1 = 1'b1; v1 = 1'b1;
    tick(1);
    v1 = 1'b0;
    tick(8);
    check("post_rst_sum", s1, 8'h47);
    check("post_rst_valid", ov1, 1);
    or1 = 1'b1;
    tick(1);
    or1 = 1'b0;

`ifdef SERIAL_ADD_UNIT_SUB_EN
    a1 = 8'h10; b1 = 8'h20; c1 = 1'b1; sub1 = 1'b1; v1 = 1'b1;
    tick(1);
    v1 = 1'b0;
    tick(8);
    check("sub_1_sum", s1, 8'hF0);
    check("sub_1_cout", co1, 0);
    or1 = 1'b1;
    tick(1);
    or1 = 1'b0;
    a1 = 8'h20; b1 = 8'h10; c1 = 1'b0; v1 = 1'b1;
    tick(1);
    v1 = 1'b0;
    tick(8);
    check("sub_2_sum", s1, 8'h10);
    check("sub_2_cout", co1, 1);
    or1 = 1'b1; sub1 = 1'b0;
    tick(1);
    or1 = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
